// File: rtl/l2_request_arbiter.sv
// L2 front-end arbiter: fixed-priority fill queue over round-robin cores, one registered grant per cycle.
// Optional L2_ARB_STARVE_GUARD_EN bounds consecutive fill grants to MAX_FILL_BURST while a core waits.
module l2_request_arbiter #(
  parameter int NUM_CORES      = 4,
  parameter int ADDR_WIDTH     = 26,
  parameter int LINE_BITS      = 512,
  parameter int MAX_FILL_BURST = 4,
  localparam int CW            = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CORES-1:0]            core_req_valid,
  input  logic [3*NUM_CORES-1:0]          core_req_op,
  input  logic [ADDR_WIDTH*NUM_CORES-1:0] core_req_addr,
  output logic [NUM_CORES-1:0]            core_req_ack,
  input  logic                            fill_valid,
  input  logic [2:0]                      fill_op,
  input  logic [ADDR_WIDTH-1:0]           fill_addr,
  input  logic [CW-1:0]                   fill_core,
  input  logic [1:0]                      fill_way,
  input  logic [LINE_BITS-1:0]            fill_data,
  output logic                            fill_ack,
  input  logic                            stall,
  output logic                            arb_valid,
  output logic [2:0]                      arb_op,
  output logic [ADDR_WIDTH-1:0]           arb_addr,
  output logic [CW-1:0]                   arb_core,
  output logic                            arb_is_l2_fill,
  output logic [1:0]                      arb_fill_way,
  output logic [LINE_BITS-1:0]            arb_data
);

  if (NUM_CORES < 1 || NUM_CORES > 8 || MAX_FILL_BURST < 1) begin : g_bad_cfg
    $error("l2_request_arbiter: unsupported NUM_CORES/MAX_FILL_BURST");
  end

  logic [CW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]         rr_idx, cand;
  logic                  rr_hit;
  logic                  core_any, force_core;
  logic                  grant_fill, grant_core;
  logic [2:0]            sel_op;
  logic [ADDR_WIDTH-1:0] sel_addr;

  logic                  arb_valid_q, arb_is_l2_fill_q;
  logic [2:0]            arb_op_q;
  logic [ADDR_WIDTH-1:0] arb_addr_q;
  logic [CW-1:0]         arb_core_q;
  logic [1:0]            arb_fill_way_q;
  logic [LINE_BITS-1:0]  arb_data_q;

  // First valid core at or after rr_ptr, scanning upward with wrap.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    cand   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cand = CW'((int'(rr_ptr_q) + i) % NUM_CORES);
      if (!rr_hit && core_req_valid[cand]) begin
        rr_hit = 1'b1;
        rr_idx = cand;
      end
    end
  end

  assign core_any = |core_req_valid;

`ifdef L2_ARB_STARVE_GUARD_EN
  localparam int BW = $clog2(MAX_FILL_BURST + 1);
  logic [BW-1:0] fill_burst_cnt_q;

  assign force_core = (fill_burst_cnt_q == BW'(MAX_FILL_BURST)) && core_any;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_burst_cnt_q <= '0;
    end else if (grant_core || !core_any) begin
      fill_burst_cnt_q <= '0;
    end else if (grant_fill && fill_burst_cnt_q != BW'(MAX_FILL_BURST)) begin
      fill_burst_cnt_q <= fill_burst_cnt_q + BW'(1);
    end
  end
`else
  assign force_core = 1'b0;
`endif

  assign grant_fill = !reset && !stall && fill_valid && !force_core;
  assign grant_core = !reset && !stall && rr_hit && !grant_fill;
  assign fill_ack   = grant_fill;

  always_comb begin
    core_req_ack = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      core_req_ack[i] = grant_core && (rr_idx == CW'(i));
    end
  end

  assign sel_op   = core_req_op[rr_idx*3 +: 3];
  assign sel_addr = core_req_addr[rr_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign rr_ptr_d = (NUM_CORES == 1) ? '0 :
                    grant_core       ? CW'((int'(rr_idx) + 1) % NUM_CORES) : rr_ptr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q         <= '0;
      arb_valid_q      <= 1'b0;
      arb_op_q         <= '0;
      arb_addr_q       <= '0;
      arb_core_q       <= '0;
      arb_is_l2_fill_q <= 1'b0;
      arb_fill_way_q   <= '0;
      arb_data_q       <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      arb_valid_q <= grant_fill || grant_core;
      // Payload only moves on a grant; idle cycles keep the last request visible.
      if (grant_fill) begin
        arb_op_q         <= fill_op;
        arb_addr_q       <= fill_addr;
        arb_core_q       <= fill_core;
        arb_is_l2_fill_q <= 1'b1;
        arb_fill_way_q   <= fill_way;
        arb_data_q       <= fill_data;
      end else if (grant_core) begin
        arb_op_q         <= sel_op;
        arb_addr_q       <= sel_addr;
        arb_core_q       <= rr_idx;
        arb_is_l2_fill_q <= 1'b0;
        arb_fill_way_q   <= '0;
        arb_data_q       <= '0;
      end
    end
  end

  assign arb_valid      = arb_valid_q;
  assign arb_op         = arb_op_q;
  assign arb_addr       = arb_addr_q;
  assign arb_core       = arb_core_q;
  assign arb_is_l2_fill = arb_is_l2_fill_q;
  assign arb_fill_way   = arb_fill_way_q;
  assign arb_data       = arb_data_q;

`ifndef SYNTHESIS
  a_ack_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(core_req_ack));
  a_ack_exclusive: assert property (@(posedge clk) disable iff (reset) !(fill_ack && |core_req_ack));
`endif

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Randomized + directed bench for l2_request_arbiter against a cycle-level behavioural model.
module tb_l2_request_arbiter;
  localparam int N = 4, AW = 26, LB = 512, MAXB = 4, CW = 2;
`ifdef L2_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0, reset = 1'b1, stall = 1'b0;
  logic [N-1:0]  core_req_valid = '0, core_req_ack;
  logic [3*N-1:0] core_req_op = '0;
  logic [AW*N-1:0] core_req_addr = '0;
  logic          fill_valid = 1'b0, fill_ack;
  logic [2:0]    fill_op = '0;
  logic [AW-1:0] fill_addr = '0;
  logic [CW-1:0] fill_core = '0;
  logic [1:0]    fill_way = '0;
  logic [LB-1:0] fill_data = '0;
  logic          arb_valid, arb_is_l2_fill;
  logic [2:0]    arb_op;
  logic [AW-1:0] arb_addr;
  logic [CW-1:0] arb_core;
  logic [1:0]    arb_fill_way;
  logic [LB-1:0] arb_data;

  l2_request_arbiter #(.NUM_CORES(N), .ADDR_WIDTH(AW), .LINE_BITS(LB), .MAX_FILL_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .core_req_valid(core_req_valid), .core_req_op(core_req_op), .core_req_addr(core_req_addr),
    .core_req_ack(core_req_ack),
    .fill_valid(fill_valid), .fill_op(fill_op), .fill_addr(fill_addr), .fill_core(fill_core),
    .fill_way(fill_way), .fill_data(fill_data), .fill_ack(fill_ack),
    .stall(stall),
    .arb_valid(arb_valid), .arb_op(arb_op), .arb_addr(arb_addr), .arb_core(arb_core),
    .arb_is_l2_fill(arb_is_l2_fill), .arb_fill_way(arb_fill_way), .arb_data(arb_data)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  // Model of the registered tag-stage request plus arbitration state.
  int            m_rr, m_cnt;
  logic          m_vld, m_fill;
  logic [2:0]    m_op;
  logic [AW-1:0] m_addr;
  logic [CW-1:0] m_core;
  logic [1:0]    m_way;
  logic [LB-1:0] m_data;
  logic [N-1:0]  cap_core_ack;
  logic          cap_fill_ack;

  task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_cnt = 0; m_vld = 0; m_fill = 0; m_op = '0; m_addr = '0;
    m_core = '0; m_way = '0; m_data = '0;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_arb_valid", arb_valid, 0);
    chk("rst_core_ack", core_req_ack, 0);
    chk("rst_fill_ack", fill_ack, 0);
    chk("rst_payload", {arb_is_l2_fill, arb_op, arb_addr, arb_core, arb_fill_way}, 0);
    chk("rst_data", arb_data, 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One clock: compare at negedge, advance model at posedge, return 1 unit after the edge.
  task automatic step();
    logic [N-1:0] eack;
    logic efill;
    int win;
    bit any, frc;
    @(negedge clk);
    eack = '0; efill = 1'b0; win = -1;
    any = |core_req_valid;
    frc = GUARD && (m_cnt == MAXB) && any;
    if (!reset && !stall) begin
      if (fill_valid && !frc) efill = 1'b1;
      else begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_rr + k) % N;
          if (win < 0 && core_req_valid[c]) win = c;
        end
      end
      if (win >= 0) eack[win] = 1'b1;
    end
    chk("core_req_ack", core_req_ack, eack);
    chk("fill_ack", fill_ack, efill);
    chk("arb_valid", arb_valid, m_vld);
    chk("arb_op", arb_op, m_op);
    chk("arb_addr", arb_addr, m_addr);
    chk("arb_core", arb_core, m_core);
    chk("arb_is_l2_fill", arb_is_l2_fill, m_fill);
    chk("arb_fill_way", arb_fill_way, m_way);
    chk("arb_data", arb_data, m_data);
    cap_core_ack = core_req_ack;
    cap_fill_ack = fill_ack;
    @(posedge clk);
    if (efill) begin
      m_vld = 1; m_fill = 1; m_op = fill_op; m_addr = fill_addr; m_core = fill_core;
      m_way = fill_way; m_data = fill_data;
      m_cnt = any ? ((m_cnt + 1 > MAXB) ? MAXB : m_cnt + 1) : 0;
    end else if (win >= 0) begin
      m_vld = 1; m_fill = 0; m_op = core_req_op[win*3 +: 3];
      m_addr = core_req_addr[win*AW +: AW]; m_core = CW'(win); m_way = '0; m_data = '0;
      m_rr = (win + 1) % N; m_cnt = 0;
    end else begin
      m_vld = 0;
      if (!any) m_cnt = 0;
    end
    #1;
  endtask

  task automatic set_core(input int c, input logic [2:0] op, input logic [AW-1:0] addr);
    core_req_valid[c] = 1'b1;
    core_req_op[c*3 +: 3] = op;
    core_req_addr[c*AW +: AW] = addr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int order [8];
    logic [LB-1:0] fdat;
    order = '{0, 1, 2, 3, 0, 1, 2, 3};
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Single core 2 LOAD request.
    set_core(2, 3'd1, 26'h0001234);
    step();
    chk("t1_ack", cap_core_ack, 4'b0100);
    core_req_valid = '0;
    chk("t1_valid", arb_valid, 1);
    chk("t1_core", arb_core, 2);
    chk("t1_addr", arb_addr, 26'h0001234);
    chk("t1_fill", arb_is_l2_fill, 0);
    chk("t1_data", arb_data, 0);

    // Round-robin across four held cores, then confirm the pointer wrapped to 0.
    do_reset();
    for (int c = 0; c < N; c++) set_core(c, 3'(c), AW'(16 * c + 5));
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t2_order", cap_core_ack, 4'b1 << order[k]);
    end
    step();
    chk("t2_wrap", cap_core_ack, 4'b0001);
    core_req_valid = '0;

    // Fill beats a waiting core, core follows next cycle.
    fdat = {16{32'hA5C3_0F01}};
    fill_valid = 1'b1; fill_op = 3'd2; fill_addr = 26'h2AB_CDEF; fill_core = 2'd3;
    fill_way = 2'd2; fill_data = fdat;
    set_core(1, 3'd3, 26'h0000777);
    step();
    chk("t3_fill_ack", cap_fill_ack, 1);
    chk("t3_core_ack", cap_core_ack, 0);
    fill_valid = 1'b0;
    chk("t3_is_fill", arb_is_l2_fill, 1);
    chk("t3_way", arb_fill_way, 2'd2);
    chk("t3_data", arb_data, fdat);
    chk("t3_core", arb_core, 2'd3);
    step();
    chk("t3_core_next", cap_core_ack, 4'b0010);
    core_req_valid = '0;

    // Stall holds off a pending core.
    set_core(0, 3'd1, 26'h0000042);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t4_stall_ack", cap_core_ack, 0);
      chk("t4_stall_valid", arb_valid, 0);
    end
    stall = 1'b0;
    step();
    chk("t4_release_ack", cap_core_ack, 4'b0001);
    core_req_valid = '0;

    // Continuous fill against core 3: guard forces every fifth grant to the core.
    do_reset();
    fill_valid = 1'b1;
    set_core(3, 3'd1, 26'h0000333);
    for (int k = 0; k < 10; k++) begin
      bit core_turn;
      core_turn = GUARD && (k % 5 == 4);
      step();
      chk("t5_fill_ack", cap_fill_ack, !core_turn);
      chk("t5_core_ack", cap_core_ack, core_turn ? 4'b1000 : 4'b0000);
    end
    fill_valid = 1'b0;
    core_req_valid = '0;

    // Reset while a request is registered; held cores 1 and 3 restart from pointer 0.
    set_core(1, 3'd4, 26'h0000111);
    set_core(3, 3'd5, 26'h0000333);
    step();
    chk("t6_pre_ack", cap_core_ack, 4'b0010);
    chk("t6_pre_valid", arb_valid, 1);
    do_reset();
    step();
    chk("t6_post_ack", cap_core_ack, 4'b0010);
    core_req_valid = '0;

    // Randomized traffic obeying hold-until-ack.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc == 1000) do_reset();
      for (int c = 0; c < N; c++)
        if (!core_req_valid[c] && $urandom_range(0, 2) == 0)
          set_core(c, 3'($urandom), AW'($urandom));
      if (!fill_valid && $urandom_range(0, 3) == 0) begin
        fill_valid = 1'b1; fill_op = 3'($urandom); fill_addr = AW'($urandom);
        fill_core = CW'($urandom); fill_way = 2'($urandom);
        for (int w = 0; w < LB / 32; w++) fill_data[w*32 +: 32] = $urandom;
      end
      stall = ($urandom_range(0, 4) == 0);
      step();
      core_req_valid = core_req_valid & ~cap_core_ack;
      if (cap_fill_ack) fill_valid = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/l2_request_arbiter.md
# l2_request_arbiter

Front-end scheduler for the L2 cache pipeline. Each cycle it selects one request for the tag stage, from either the per-core L2 request queues or the restarted-miss fill queue that returns from the memory interface. It registers the winner onto the tag-stage inputs. Fills have fixed priority, cores are served round-robin, and an optional starvation guard bounds consecutive fill grants.

## Interface
- NUM_CORES, default 4: number of core requesters, power of two, 1–8.
- ADDR_WIDTH, default 26: cache-line address width.
- LINE_BITS, default 512: cache line width.
- MAX_FILL_BURST, default 4: consecutive fill grants before a core must be granted. Used only with the guard macro.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- core_req_valid  in  NUM_CORES  per-core request pending.
- core_req_op  in  3*NUM_CORES  per-core opcode.
- core_req_addr  in  ADDR_WIDTH*NUM_CORES  per-core line address.
- core_req_ack  out  NUM_CORES  one-hot; the core's request was accepted this cycle.
- fill_valid  in  1  restarted miss with data ready.
- fill_op  in  3  opcode of the original request.
- fill_addr  in  ADDR_WIDTH  line address.
- fill_core  in  log2(NUM_CORES)  original requester.
- fill_way  in  2  victim way chosen for the fill.
- fill_data  in  LINE_BITS  line data from memory.
- fill_ack  out  1  fill accepted this cycle.
- stall  in  1  downstream cannot accept a request (writeback or response queue almost full).
- arb_valid  out  1  registered request valid to the tag stage.
- arb_op  out  3  registered opcode.
- arb_addr  out  ADDR_WIDTH  registered address.
- arb_core  out  log2(NUM_CORES)  registered requesting core.
- arb_is_l2_fill  out  1  registered fill flag.
- arb_fill_way  out  2  registered fill way.
- arb_data  out  LINE_BITS  registered fill data. Zero for core requests.

## Operation
- Grant is computed combinationally. Outputs are registered. Acks are combinational in the grant cycle.
- If stall = 1, there is no grant, all acks are 0, and arb_valid <= 0 on the next edge.
- Priority when not stalled:
  - fill_valid wins by default.
  - Otherwise the first valid core at or after rr_ptr, in ascending order with wrap, wins.
- rr_ptr resets to 0. It advances to (granted core + 1) mod NUM_CORES only on a core grant. It is unchanged on fill grants and on idle cycles.
- The request transfers on the clock edge of its grant cycle. Requesters hold valid and payload stable until acked.
- arb_core carries fill_core for a fill grant and the granted index for a core grant.
- On idle (no grant), arb_valid <= 0. Payload registers hold their previous values.

## Timing
- Latency: exactly 1 cycle from grant to arb_valid. Back-to-back throughput is 1 request per cycle.
- Reset values of all outputs:
  - arb_valid, arb_is_l2_fill, arb_op, arb_addr, arb_core, arb_fill_way = 0.
  - arb_data = 0.
  - fill_burst_cnt = 0.
  - Combinational acks are 0 while reset is asserted.
- Reset asserted mid-operation clears the registered request immediately. Any in-flight unacked request is re-arbitrated after reset deasserts.
- Stall asserted in the same cycle as valid inputs: no ack. The request is presented again the next cycle.
- Fill and all cores valid simultaneously: the fill wins unless the starvation guard forces a core grant.
- Single core, NUM_CORES = 1: rr_ptr is a constant 0.
- Assertions:
  - core_req_ack is onehot0.
  - core_req_ack and fill_ack are never both 1.

## Configuration
- L2_ARB_STARVE_GUARD_EN defined:
  - fill_burst_cnt, 0..MAX_FILL_BURST, increments on each fill grant.
  - It clears on any core grant and on any cycle with no valid core request.
  - When it equals MAX_FILL_BURST and a core request is valid, the round-robin core wins over fill_valid. The counter then clears.
- Not defined: no counter is built, and fills always win over cores.

## Test plan
- Reset, then core 2 valid alone with op=LOAD, addr=0x0001234 -> core_req_ack=4'b0100 that cycle; next cycle arb_valid=1, arb_core=2, arb_addr=0x0001234, arb_is_l2_fill=0, arb_data=0.
- Cores 0–3 held valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; rr_ptr returns to 0.
- Fill valid together with core 1 -> fill_ack=1, core_req_ack=0; next cycle arb_is_l2_fill=1, arb_fill_way=fill_way, arb_data=fill_data; core 1 is granted the following cycle.
- Stall=1 for 3 cycles with core 0 valid -> no ack, arb_valid=0; stall drops -> ack on the first unstalled cycle.
- Guard enabled, MAX_FILL_BURST=4, fill and core 3 continuously valid -> 4 fill grants, then a core 3 grant, then 4 fills again. Guard disabled -> fills only.
- Reset asserted while arb_valid=1 -> arb_valid=0 immediately; after release, a held core request is acked again with rr_ptr=0.
